ldo_seq_ctrl: RTL and testbench



---
 rtl/ldo_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_ldo_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldo_seq_ctrl.sv
// ldo_seq_ctrl: power-up / power-down sequencer for N_CH on-chip LDO channels.
//
// Brings channels up one at a time. Each channel's enable is raised, then its
// reference code is ramped from 0 to the latched target. The sequencer then waits
// (bounded) for that channel's power-good before moving to the next channel.
// Power-down releases channels in reverse order with a fixed spacing. A missing or
// dropped power-good parks the sequencer in FAULT with every channel off.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   req        level request: 1 = power up all channels, 0 = power down
//   target     final reference code (latched when leaving OFF)
//   pg_async   power-good comparators, asynchronous to clk (synchronised here)
//   clr_fault  fault clear pulse (honoured only together with req = 0)
//   en         per-channel LDO enable
//   code       per-channel soft-start code, channel i at [i*CODE_W +: CODE_W]
//   all_good   all channels up and power-good
//   busy       sequencing in progress (ramp, wait for power-good, power-down)
//   fault      sequencer in FAULT
//   fault_ch   index of the channel that caused the fault
module ldo_seq_ctrl #(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned CODE_W   = 6,
  parameter int unsigned STEP     = 4,
  parameter int unsigned RAMP_DIV = 8,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned OFF_DLY  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req,
  input  logic [CODE_W-1:0]      target,
  input  logic [N_CH-1:0]        pg_async,
  input  logic                   clr_fault,
  output logic [N_CH-1:0]        en,
  output logic [N_CH*CODE_W-1:0] code,
  output logic                   all_good,
  output logic                   busy,
  output logic                   fault,
  output logic [2:0]             fault_ch
);

  localparam int unsigned ChW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CntMax0 = (RAMP_DIV > TIMEOUT) ? RAMP_DIV : TIMEOUT;
  localparam int unsigned CntMax  = (CntMax0 > OFF_DLY) ? CntMax0 : OFF_DLY;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [ChW-1:0]  LastCh   = ChW'(N_CH - 1);
  localparam logic [CntW-1:0] RampLast = CntW'(RAMP_DIV - 1);
  localparam logic [CntW-1:0] ToLast   = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] OffLast  = CntW'(OFF_DLY - 1);

  typedef enum logic [2:0] {
    StOff,
    StRamp,
    StWaitPg,
    StOn,
    StDown,
    StFault
  } state_e;

  state_e                         state_q, state_d;
  logic [ChW-1:0]                 ch_q, ch_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [CODE_W-1:0]              tgt_q, tgt_d;
  logic [N_CH-1:0]                en_q, en_d;
  logic [N_CH-1:0][CODE_W-1:0]    code_q, code_d;
  logic                           all_good_q, all_good_d;
  logic                           busy_q, busy_d;
  logic                           fault_q, fault_d;
  logic [2:0]                     fault_ch_q, fault_ch_d;
  logic [N_CH-1:0]                pg_meta_q, pg_s_q;

  logic [ChW-1:0]                 ch_nxt, ch_prv, low_idx;
  logic [CODE_W:0]                ramp_sum;
  logic [CODE_W-1:0]              ramp_next;

  assign ch_nxt = ch_q + 1'b1;
  assign ch_prv = ch_q - 1'b1;

  // One extra bit so that code + STEP can never wrap past the target.
  always_comb begin
    ramp_sum = {1'b0, code_q[ch_q]} + (CODE_W + 1)'(STEP);
    if (ramp_sum >= {1'b0, tgt_q}) begin
      ramp_next = tgt_q;
    end else begin
      ramp_next = ramp_sum[CODE_W-1:0];
    end
  end

  // Lowest channel whose synchronised power-good is low.
  always_comb begin
    low_idx = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (!pg_s_q[i]) begin
        low_idx = ChW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    en_d       = en_q;
    code_d     = code_q;
    fault_ch_d = fault_ch_q;

    unique case (state_q)
      StOff: begin
        if (req) begin
          tgt_d     = target;
          ch_d      = '0;
          cnt_d     = '0;
          en_d[0]   = 1'b1;
          code_d[0] = '0;
          state_d   = StRamp;
        end
      end

      StRamp: begin
        if (!req) begin
          // Abort: the channel being ramped is the first one released.
          en_d[ch_q]   = 1'b0;
          code_d[ch_q] = '0;
          cnt_d        = '0;
          state_d      = StDown;
        end else if (code_q[ch_q] == tgt_q) begin
          cnt_d   = '0;
          state_d = StWaitPg;
        end else if (cnt_q == RampLast) begin
          cnt_d        = '0;
          code_d[ch_q] = ramp_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWaitPg: begin
        if (!req) begin
          en_d[ch_q]   = 1'b0;
          code_d[ch_q] = '0;
          cnt_d        = '0;
          state_d      = StDown;
        end else if (pg_s_q[ch_q]) begin
          // Checked before the timeout so a last-cycle power-good still counts.
          cnt_d = '0;
          if (ch_q == LastCh) begin
            state_d = StOn;
          end else begin
            ch_d           = ch_nxt;
            en_d[ch_nxt]   = 1'b1;
            code_d[ch_nxt] = '0;
            state_d        = StRamp;
          end
        end else if (cnt_q == ToLast) begin
          fault_ch_d = 3'(ch_q);
          en_d       = '0;
          code_d     = '0;
          state_d    = StFault;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StOn: begin
        if (pg_s_q != {N_CH{1'b1}}) begin
          fault_ch_d = 3'(low_idx);
          en_d       = '0;
          code_d     = '0;
          state_d    = StFault;
        end else if (!req) begin
          ch_d           = LastCh;
          en_d[LastCh]   = 1'b0;
          code_d[LastCh] = '0;
          cnt_d          = '0;
          state_d        = StDown;
        end
      end

      StDown: begin
        // req is ignored here; a new power-up only starts from OFF.
        if (cnt_q == OffLast) begin
          cnt_d = '0;
          if (ch_q == '0) begin
            state_d = StOff;
          end else begin
            ch_d           = ch_prv;
            en_d[ch_prv]   = 1'b0;
            code_d[ch_prv] = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StFault: begin
        if (clr_fault && !req) begin
          fault_ch_d = '0;
          state_d    = StOff;
        end
      end

      default: begin
        en_d       = '0;
        code_d     = '0;
        fault_ch_d = '0;
        state_d    = StOff;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    all_good_d = (state_d == StOn);
    busy_d     = (state_d == StRamp) || (state_d == StWaitPg) || (state_d == StDown);
    fault_d    = (state_d == StFault);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StOff;
      ch_q       <= '0;
      cnt_q      <= '0;
      tgt_q      <= '0;
      en_q       <= '0;
      code_q     <= '0;
      all_good_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_ch_q <= '0;
      pg_meta_q  <= '0;
      pg_s_q     <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      en_q       <= en_d;
      code_q     <= code_d;
      all_good_q <= all_good_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      fault_ch_q <= fault_ch_d;
      pg_meta_q  <= pg_async;
      pg_s_q     <= pg_meta_q;
    end
  end

  assign en       = en_q;
  assign code     = code_q;
  assign all_good = all_good_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign fault_ch = fault_ch_q;

endmodule

// File: tb/tb_ldo_seq_ctrl.sv
// Self-checking bench for ldo_seq_ctrl (N_CH=3, CODE_W=6, STEP=4, RAMP_DIV=8,
// TIMEOUT=64, OFF_DLY=16). Expected waveforms come from a timing schedule worked
// out arithmetically from the channel ramp length and each channel's power-good delay.
module tb_ldo_seq_ctrl;

  localparam int NCh     = 3;
  localparam int CodeW   = 6;
  localparam int Step    = 4;
  localparam int RampDiv = 8;
  localparam int Timeout = 64;
  localparam int OffDly  = 16;
  localparam int OutW    = NCh * (CodeW + 1) + 6;
  localparam int Never   = 1000000;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic                   req = 1'b0;
  logic                   clr_fault = 1'b0;
  logic [CodeW-1:0]       target = '0;
  logic [NCh-1:0]         pg_async = '0;
  logic [NCh-1:0]         en;
  logic [NCh*CodeW-1:0]   code;
  logic                   all_good, busy, fault;
  logic [2:0]             fault_ch;
  logic [OutW-1:0]        act;

  int checks = 0;
  int errors = 0;

  // Schedule produced by plan(): sample index k counts clock edges from the
  // edge at which the sequencer leaves OFF (k = 0 is when en[0] rises).
  int m_tgt;
  int m_dly[NCh];   // cycles from en[i] rising until pg_async[i] is driven high
  int m_rise[NCh];
  int m_on, m_flt, m_fch;

  typedef struct packed {
    int tgt;
    int d0;
    int d1;
    int d2;
    int exp_end;
    int exp_fault;
    int exp_fch;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  assign act = {en, code, all_good, busy, fault, fault_ch};

  ldo_seq_ctrl #(
    .N_CH    (NCh),
    .CODE_W  (CodeW),
    .STEP    (Step),
    .RAMP_DIV(RampDiv),
    .TIMEOUT (Timeout),
    .OFF_DLY (OffDly)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .target   (target),
    .pg_async (pg_async),
    .clr_fault(clr_fault),
    .en       (en),
    .code     (code),
    .all_good (all_good),
    .busy     (busy),
    .fault    (fault),
    .fault_ch (fault_ch)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int ramp_len(input int tgt);
    return RampDiv * ((tgt + Step - 1) / Step);
  endfunction

  // Channel i: ramp occupies ramp_len cycles, WAIT_PG begins one cycle later.
  // Power-good is seen two cycles after it is driven (synchroniser).
  task automatic plan();
    int t, w, p;
    t = 0;
    m_on = Never;
    m_flt = Never;
    m_fch = 0;
    for (int i = 0; i < NCh; i++) m_rise[i] = Never;
    for (int i = 0; i < NCh; i++) begin
      m_rise[i] = t;
      w = t + ramp_len(m_tgt) + 1;
      if (m_dly[i] >= Never) p = Never;
      else p = (t + m_dly[i] + 2 > w) ? t + m_dly[i] + 2 : w;
      if (p <= w + Timeout - 1) begin
        t = p + 1;
      end else begin
        m_flt = w + Timeout;
        m_fch = i;
        break;
      end
    end
    if (m_flt == Never) m_on = t;
  endtask

  function automatic logic [OutW-1:0] exp_up(input int k);
    logic [NCh-1:0]       e;
    logic [NCh*CodeW-1:0] c;
    int                   v;
    e = '0;
    c = '0;
    if (k >= m_flt) return {e, c, 1'b0, 1'b0, 1'b1, 3'(m_fch)};
    for (int j = 0; j < NCh; j++) begin
      if (k >= m_rise[j]) begin
        e[j] = 1'b1;
        v = ((k - m_rise[j]) / RampDiv) * Step;
        if (v > m_tgt) v = m_tgt;
        c[j*CodeW +: CodeW] = CodeW'(v);
      end
    end
    return {e, c, (k >= m_on), (k < m_on), 1'b0, 3'b000};
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    req = 1'b0;
    clr_fault = 1'b0;
    pg_async = '0;
    #1;
    check("reset outputs", act, '0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Caller is 1 time unit after a rising edge; the next edge is sample k = 0.
  task automatic run_up(output int obs);
    int last;
    plan();
    obs = -1;
    target = CodeW'(m_tgt);
    req = 1'b1;
    last = ((m_on < m_flt) ? m_on : m_flt) + 2;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("up k=%0d", k), act, exp_up(k));
      if (obs < 0 && (all_good || fault)) obs = k;
      for (int j = 0; j < NCh; j++) begin
        if (k == m_rise[j] + m_dly[j]) pg_async[j] = 1'b1;
      end
    end
  endtask

  task automatic run_down(input int hold);
    logic [NCh-1:0]       e;
    logic [NCh*CodeW-1:0] c;
    int                   lim;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("on hold all_good", all_good, 1'b1);
    end
    req = 1'b0;
    for (int k = 0; k <= NCh * OffDly + 2; k++) begin
      @(posedge clk);
      #1;
      e = '0;
      c = '0;
      lim = NCh - 1 - k / OffDly;
      for (int j = 0; j < NCh; j++) begin
        if (j < lim) begin
          e[j] = 1'b1;
          c[j*CodeW +: CodeW] = CodeW'(m_tgt);
        end
      end
      check($sformatf("down k=%0d", k), act,
            {e, c, 1'b0, (k < NCh * OffDly), 1'b0, 3'b000});
    end
  endtask

  task automatic fault_clear_seq();
    clr_fault = 1'b1;
    req = 1'b1;
    @(posedge clk);
    #1;
    check("clr with req=1 ignored", fault, 1'b1);
    clr_fault = 1'b0;
    req = 1'b0;
    @(posedge clk);
    #1;
    check("fault held without clr", fault, 1'b1);
    clr_fault = 1'b1;
    @(posedge clk);
    #1;
    clr_fault = 1'b0;
    check("fault cleared to off", act, '0);
    repeat (3) @(posedge clk);
    #1;
    check("off stays idle", act, '0);
  endtask

  initial begin
    int obs;
    int waited;
    int rl;

    // tgt, pg delays per channel, end cycle (all_good or fault), fault, fault_ch
    vecs[0] = '{40, 10, 10, 10, 246, 0, 0};
    vecs[1] = '{42, 10, 10, 10, 270, 0, 0};
    vecs[2] = '{0, 10, 10, 10, 39, 0, 0};
    vecs[3] = '{40, 10, Never, 10, 227, 1, 1};
    vecs[4] = '{40, 142, 10, 10, 309, 0, 0};   // pg on the last allowed cycle
    vecs[5] = '{40, 143, 10, 10, 145, 1, 0};   // pg one cycle too late
    vecs[6] = '{63, 0, 0, 0, 390, 0, 0};
    vecs[7] = '{1, 0, 0, 0, 30, 0, 0};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      m_tgt = vecs[i].tgt;
      m_dly[0] = vecs[i].d0;
      m_dly[1] = vecs[i].d1;
      m_dly[2] = vecs[i].d2;
      run_up(obs);
      check($sformatf("vec%0d end cycle", i), obs, vecs[i].exp_end);
      check($sformatf("vec%0d fault", i), fault, vecs[i].exp_fault[0]);
      check($sformatf("vec%0d fault_ch", i), fault_ch, vecs[i].exp_fch[2:0]);
      if (vecs[i].exp_fault != 0) fault_clear_seq();
      else if (i == 0) run_down(3);
    end

    // pg[2] drops and req falls so that both reach the FSM on the same edge.
    do_reset();
    m_tgt = 40;
    for (int j = 0; j < NCh; j++) m_dly[j] = 10;
    run_up(obs);
    pg_async[2] = 1'b0;
    @(posedge clk);
    #1;
    check("pg drop in sync", all_good, 1'b1);
    @(posedge clk);
    #1;
    check("pg drop still on", all_good, 1'b1);
    req = 1'b0;
    @(posedge clk);
    #1;
    check("drop+req fault wins", act, {{(NCh * (CodeW + 1) + 2){1'b0}}, 1'b1, 3'd2});

    // Asynchronous reset in the middle of channel 1's ramp, then a clean restart.
    do_reset();
    pg_async = '1;
    target = 6'd40;
    req = 1'b1;
    waited = 0;
    while (en !== 3'b011 && waited < 400) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("reached ch1 ramp", en, 3'b011);
    repeat (20) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("async reset mid-ramp", act, '0);
    pg_async = '0;
    @(posedge clk);
    #1;
    check("held in reset", act, '0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    m_tgt = 40;
    for (int j = 0; j < NCh; j++) m_dly[j] = 10;
    run_up(obs);
    check("restart end cycle", obs, 246);

    // Randomised runs against the schedule model.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      m_tgt = int'($urandom_range(0, 63));
      rl = ramp_len(m_tgt);
      for (int j = 0; j < NCh; j++) begin
        if ($urandom_range(0, 3) == 0) m_dly[j] = int'($urandom_range(rl + 55, rl + 70));
        else m_dly[j] = int'($urandom_range(0, rl + 8));
      end
      run_up(obs);
      if (m_on < Never) run_down(int'($urandom_range(0, 5)));
      else fault_clear_seq();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
